// File: rtl/spread.sv
// rtl/spread.sv - direct-sequence spreader: each accepted data bit becomes SPREAD chips.
// Chip k is the latched data bit XORed with CODE[SPREAD-1-k]; all outputs are registered.
module spread #(
    parameter int                SPREAD = 24,
    parameter logic [SPREAD-1:0] CODE   = 24'hE25B34
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_ready,
    input  logic i_data,
    input  logic i_valid,
    output logic o_data,
    output logic o_valid
);

    localparam int CW = $clog2(SPREAD + 1);
    localparam int CD = 2 ** CW;
    localparam logic [CW-1:0] LAST = CW'(SPREAD);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_q, bit_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          data_q, data_d;
    logic [CD-1:0] code_rev;
    logic          accept;
    logic          last;

    // Code reversed and zero-padded so the chip counter indexes it directly.
    for (genvar k = 0; k < CD; k++) begin : g_code
        if (k < SPREAD) begin : g_on
            assign code_rev[k] = CODE[SPREAD-1-k];
        end else begin : g_off
            assign code_rev[k] = 1'b0;
        end
    end

    // ready_q is low on the first edge after reset, which blocks an accept there.
    assign accept = (state_q == IDLE) && ready_q && i_valid;
    assign last   = (cnt_q == LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ready_d = ready_q;
        valid_d = valid_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                data_d  = 1'b0;
                if (accept) begin
                    ready_d = 1'b0;
                    valid_d = 1'b1;
                    data_d  = i_data ^ code_rev[0];
                    cnt_d   = CW'(1);
                    bit_d   = i_data;
                end
            end
            BUSY: begin
                if (last) begin
                    ready_d = 1'b1;
                    valid_d = 1'b0;
                    data_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    ready_d = 1'b0;
                    valid_d = 1'b1;
                    data_d  = bit_q ^ code_rev[cnt_q];
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                ready_d = 1'b0;
                valid_d = 1'b0;
                data_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_spread.sv
// tb/tb_spread.sv - directed self-checking bench for spread (default code and a 2-chip instance).
module tb_spread;

    logic clk;
    logic rst_n;
    logic v1, d1, rdy1, od1, ov1;
    logic v2, d2, rdy2, od2, ov2;

    int n_checks = 0;
    int n_fail   = 0;

    spread u_dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .o_ready (rdy1),
        .i_data  (d1),
        .i_valid (v1),
        .o_data  (od1),
        .o_valid (ov1)
    );

    spread #(.SPREAD(2), .CODE(2'b10)) u_dut2 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .o_ready (rdy2),
        .i_data  (d2),
        .i_valid (v2),
        .o_data  (od2),
        .o_valid (ov2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge with dut1 idle; returns at the negedge of the idle gap after the burst.
    task automatic run_burst(input logic d, input logic [23:0] exp, input bit hold_valid, input string tag);
        check({tag, "_pre_ready"}, rdy1, 1'b1);
        check({tag, "_pre_valid"}, ov1, 1'b0);
        v1 = 1'b1;
        d1 = d;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            d1 = ~d1;
            if (!hold_valid) v1 = 1'b0;
            check($sformatf("%s_valid%0d", tag, k), ov1, 1'b1);
            check($sformatf("%s_ready%0d", tag, k), rdy1, 1'b0);
            check($sformatf("%s_chip%0d", tag, k), od1, exp[23-k]);
        end
        @(negedge clk);
        check({tag, "_end_valid"}, ov1, 1'b0);
        check({tag, "_end_ready"}, rdy1, 1'b1);
        check({tag, "_end_data"}, od1, 1'b0);
    endtask

    initial begin
        logic [23:0] code_p;
        logic [23:0] code_n;
        code_p = 24'hE25B34;
        code_n = 24'h1DA4CB;
        rst_n = 1'b0;
        v1 = 1'b0; d1 = 1'b0;
        v2 = 1'b0; d2 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy1, 1'b0);
        check("rst_valid", ov1, 1'b0);
        check("rst_data", od1, 1'b0);
        check("rst2_ready", rdy2, 1'b0);
        check("rst2_valid", ov2, 1'b0);

        // i_valid already high at release: first edge must only raise ready.
        rst_n = 1'b1;
        v1 = 1'b1;
        d1 = 1'b0;
        #1;
        check("rel_ready_hold", rdy1, 1'b0);
        @(negedge clk);
        check("rel_ready", rdy1, 1'b1);
        check("rel_valid", ov1, 1'b0);
        check("rel2_ready", rdy2, 1'b1);
        check("rel2_valid", ov2, 1'b0);

        run_burst(1'b0, code_p, 1'b0, "d0");
        run_burst(1'b1, code_n, 1'b0, "d1");

        run_burst(1'b1, code_n, 1'b1, "b1");
        run_burst(1'b0, code_p, 1'b1, "b2");
        run_burst(1'b1, code_n, 1'b1, "b3");
        v1 = 1'b0;
        @(negedge clk);
        check("after_b3_valid", ov1, 1'b0);
        check("after_b3_ready", rdy1, 1'b1);

        // Abort at chip 10 with an asynchronous reset between edges.
        v1 = 1'b1;
        d1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            v1 = 1'b0;
            check($sformatf("ab_chip%0d", k), od1, code_n[23-k]);
        end
        check("ab_pre_valid", ov1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ab_async_valid", ov1, 1'b0);
        check("ab_async_ready", rdy1, 1'b0);
        check("ab_async_data", od1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ab_rel_ready", rdy1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("ab_no_resid%0d", k), ov1, 1'b0);
            check($sformatf("ab2_idle%0d", k), ov2, 1'b0);
        end

        // Two-chip instance: code 10 with data 1 gives chips 0,1.
        check("s2_pre_ready", rdy2, 1'b1);
        v2 = 1'b1;
        d2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        d2 = 1'b0;
        check("s2_valid0", ov2, 1'b1);
        check("s2_chip0", od2, 1'b0);
        check("s2_ready0", rdy2, 1'b0);
        @(negedge clk);
        check("s2_valid1", ov2, 1'b1);
        check("s2_chip1", od2, 1'b1);
        check("s2_ready1", rdy2, 1'b0);
        @(negedge clk);
        check("s2_end_valid", ov2, 1'b0);
        check("s2_end_ready", rdy2, 1'b1);
        @(negedge clk);
        check("s2_stay_valid", ov2, 1'b0);
        check("s2_stay_ready", rdy2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
